// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store initiator in front of a word-wide
// data memory with a combinational read port and a single write strobe.
// Sub-word stores are done as read-modify-write (ACCESS reads, WRITE writes).
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. While busy, req_valid
// and all request fields are ignored and may change freely. resp_valid is a
// one-cycle pulse with no backpressure; resp_rdata/resp_error are meaningful
// only in that cycle and read as 0 otherwise.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_write;
  logic [1:0]              r_size;
  logic                    r_signed;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_merged;
  logic                    r_error;

  logic                    w_req_illegal;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign dbg_state   = r_state;
  // Word index; upper address bits pass through, memory applies its own wrap.
  assign mem_address = {2'b00, r_addr[ADDR_WIDTH-1:2]};
  assign resp_rdata  = (r_state == ST_RESP) ? r_rdata : '0;
  assign resp_error  = (r_state == ST_RESP) ? r_error : 1'b0;

  // Illegal = size 11, or a half/word that is not naturally aligned.
  always_comb begin
    w_req_illegal = 1'b0;
    case (req_size)
      SZ_HALF: w_req_illegal = req_addr[0];
      SZ_WORD: w_req_illegal = (req_addr[1:0] != 2'b00);
      SZ_BYTE: w_req_illegal = 1'b0;
      default: w_req_illegal = 1'b1;
    endcase
  end

  // Little-endian lane extraction and sign/zero extension of load data.
  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    w_load_data = mem_read_data;
    case (r_addr[1:0])
      2'd0:    w_byte = mem_read_data[7:0];
      2'd1:    w_byte = mem_read_data[15:8];
      2'd2:    w_byte = mem_read_data[23:16];
      default: w_byte = mem_read_data[31:24];
    endcase
    w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = mem_read_data;
    endcase
  end

  // Merge the store lane into the current memory word for sub-word stores.
  always_comb begin
    w_merged = mem_read_data;
    if (r_size == SZ_BYTE) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else begin
      if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end
  end

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and state-decoded handshake / memory strobes.
  always_comb begin
    w_next_state     = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = w_req_illegal ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!r_write) begin
          w_next_state = ST_RESP;
        end else if (r_size == SZ_WORD) begin
          mem_write_enable = 1'b1;
          mem_write_data   = r_wdata;
          w_next_state     = ST_RESP;
        end else begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_write_enable = 1'b1;
        mem_write_data   = r_merged;
        w_next_state     = ST_RESP;
      end
      default: begin
        resp_valid   = 1'b1;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Request capture on handshake, load data capture and RMW merge in ACCESS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_merged <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_error  <= w_req_illegal;
        r_rdata  <= '0;
      end
      if (r_state == ST_ACCESS) begin
        if (!r_write) r_rdata <= w_load_data;
        r_merged <= w_merged;
      end
    end
  end

endmodule
